fft_mux_sequencer: RTL and testbench
====================================

FFT_MUX_SEQUENCER -- requirements
Module: fft_mux_sequencer

Interface
REQ-001 The module SHALL have parameter LOG2N, default 5, meaning log2 of transform points (legal 3..10).
REQ-002 The module SHALL have parameter LANES, default 4, meaning number of butterfly lanes (legal 1..16).
REQ-003 The module SHALL have derived localparams CNT_W = LOG2N+1, STG_W = clog2(LOG2N+2), and OUT_STG = LOG2N+1.
REQ-004 The module SHALL use one clock and an asynchronous, active-low reset, with ports clk and rst_n.
REQ-005 The module SHALL provide these ports:
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- start  in  1  begin one transform sequence.
- stall  in  1  freeze sequencing for this cycle.
- abort  in  1  synchronous cancel.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle completion pulse.
- stage_num  out  STG_W  current stage.
- counter  out  CNT_W  cycle within stage.
- m0_s  out  1  input-load select.
- m1_s  out  2*LANES  per-lane 2-bit first-rank select; lane k at bits [2k+1:2k].
- m2_s  out  LANES  per-lane second-rank select.
- m3_s  out  2  output-rank selects.

Function
REQ-006 The module SHALL implement a state machine with states IDLE, RUN and DONE.
REQ-007 IDLE SHALL go to RUN on start=1 and abort=0; counter and stage_num SHALL be 0 in the first RUN cycle.
REQ-008 In RUN with stall=0, counter SHALL increment by 1 and wrap from 2^CNT_W-1 to 0; stage_num SHALL increment on that wrap.
REQ-009 In RUN with stall=1, counter, stage_num and all selects SHALL hold their values.
REQ-010 RUN SHALL go to DONE when stall=0, counter=2^CNT_W-1 and stage_num=OUT_STG.
REQ-011 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-012 Without stalls, busy SHALL be high for exactly (LOG2N+2)*2^CNT_W cycles.
REQ-013 busy SHALL be 1 only in RUN; done SHALL be 1 only in DONE.
REQ-014 start SHALL be ignored in RUN and in DONE.
REQ-015 abort=1 in RUN SHALL return the module to IDLE next cycle, with no done pulse, counter and stage_num at 0, and all selects at 0.
REQ-016 abort SHALL take priority over stall and over start.
REQ-017 Select outputs SHALL be registered and consistent in the same cycle with the counter and stage_num outputs; msb = counter[CNT_W-1].
REQ-018 Stage 0 (load): m0_s=1, all m1 lanes 00, m2_s=0, m3_s=00.
REQ-019 Stage 1: msb=1 gives m1 lanes 01 and m2_s all 1; msb=0 gives m1 lanes 00 and m2_s all 0; m0_s=0, m3_s=00.
REQ-020 Stages 2..LOG2N: msb=1 gives m1 lanes 01 and m2_s all 1; msb=0 gives m1 lanes 10 and m2_s all 0; m0_s=0, m3_s=00.
REQ-021 Stage OUT_STG: m1 lanes 00, m2_s=0, m0_s=0, m3_s=11.
REQ-022 In IDLE and DONE, all selects SHALL be 0.
REQ-023 stage_num values above OUT_STG are unreachable; if forced, they SHALL decode as IDLE selects.

Reset
REQ-024 On rst_n=0, the state SHALL become IDLE and busy, done, stage_num, counter, m0_s, m1_s, m2_s and m3_s SHALL all become 0 immediately, without waiting for a clock edge.
REQ-025 Reset mid-sequence SHALL discard progress with no done pulse; start SHALL be sampled from the first rising edge after rst_n deasserts.

Configuration
REQ-026 With macro FFT_LANE_MASK_EN defined, an input lane_en (LANES bits) SHALL be present.
REQ-027 With FFT_LANE_MASK_EN defined, lane_en SHALL be sampled on the cycle start is accepted and held for the whole sequence.
REQ-028 With FFT_LANE_MASK_EN defined, disabled lanes SHALL drive m1 lane=00 and m2 lane=0 in every stage; counter, stage_num, busy and done SHALL be unaffected.
REQ-029 Without FFT_LANE_MASK_EN, no lane_en port SHALL exist and all lanes SHALL always be active.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- Defaults, start pulse, no stall: busy high 448 cycles; done high at cycle 449 after start; stage_num steps 0..6; counter wraps 63 to 0 at each step.
- Stage 3 with counter 31, then 32: m1_s 0xAA (lanes 10) then 0x55 (lanes 01); m2_s 0x0 then 0xF.
- stall high 5 cycles at stage 2, counter 10: outputs frozen; total busy 453 cycles.
- abort at stage 4 together with stall=1 and start=1: next cycle IDLE, busy=0, outputs all 0, no done.
- rst_n low at stage 5: all outputs 0 asynchronously; start after release gives a full 448-cycle run.
- FFT_LANE_MASK_EN defined, lane_en=4'b0101: lanes 1 and 3 stay 00/0 throughout; lanes 0 and 2 match the unmasked pattern.

Source files
------------

// File: rtl/fft_mux_sequencer.sv
// Stage/cycle sequencer that drives the FFT datapath multiplexer selects.
// Optional per-lane masking is compiled in with `define FFT_LANE_MASK_EN.
module fft_mux_sequencer #(
    parameter int unsigned LOG2N = 5,
    parameter int unsigned LANES = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           stall,
    input  logic                           abort,
`ifdef FFT_LANE_MASK_EN
    input  logic [LANES-1:0]               lane_en,
`endif
    output logic                           busy,
    output logic                           done,
    output logic [$clog2(LOG2N+2)-1:0]     stage_num,
    output logic [LOG2N:0]                 counter,
    output logic                           m0_s,
    output logic [2*LANES-1:0]             m1_s,
    output logic [LANES-1:0]               m2_s,
    output logic [1:0]                     m3_s
);

    localparam int unsigned CNT_W   = LOG2N + 1;
    localparam int unsigned STG_W   = $clog2(LOG2N + 2);
    localparam int unsigned OUT_STG = LOG2N + 1;

    localparam logic [CNT_W-1:0] CntMax  = '1;
    localparam logic [STG_W-1:0] StgOut  = STG_W'(OUT_STG);
    localparam logic [STG_W-1:0] StgLast = STG_W'(LOG2N);
    localparam logic [STG_W-1:0] StgOne  = STG_W'(1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [STG_W-1:0]   stg_q, stg_d;
    logic               m0_q, m0_d;
    logic [2*LANES-1:0] m1_q, m1_d;
    logic [LANES-1:0]   m2_q, m2_d;
    logic [1:0]         m3_q, m3_d;
    logic [LANES-1:0]   lane_mask;

`ifdef FFT_LANE_MASK_EN
    logic [LANES-1:0]   lane_en_q, lane_en_d;
    assign lane_mask = lane_en_d;
`else
    assign lane_mask = '1;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stg_d   = stg_q;
`ifdef FFT_LANE_MASK_EN
        lane_en_d = lane_en_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    state_d = StRun;
                    cnt_d   = '0;
                    stg_d   = '0;
`ifdef FFT_LANE_MASK_EN
                    lane_en_d = lane_en;
`endif
                end
            end
            StRun: begin
                if (abort) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    stg_d   = '0;
                end else if (!stall) begin
                    if (cnt_q == CntMax && stg_q == StgOut) begin
                        state_d = StDone;
                        cnt_d   = '0;
                        stg_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == CntMax) stg_d = stg_q + 1'b1;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Selects decode from next-state values so the registered outputs line up
    // with the registered counter/stage in the same cycle.
    always_comb begin
        m0_d = 1'b0;
        m1_d = '0;
        m2_d = '0;
        m3_d = 2'b00;
        if (state_d == StRun) begin
            if (stg_d == '0) begin
                m0_d = 1'b1;
            end else if (stg_d == StgOut) begin
                m3_d = 2'b11;
            end else if (stg_d <= StgLast) begin
                for (int k = 0; k < int'(LANES); k++) begin
                    if (lane_mask[k]) begin
                        if (cnt_d[CNT_W-1]) begin
                            m1_d[2*k +: 2] = 2'b01;
                            m2_d[k]        = 1'b1;
                        end else if (stg_d != StgOne) begin
                            m1_d[2*k +: 2] = 2'b10;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            stg_q   <= '0;
            m0_q    <= 1'b0;
            m1_q    <= '0;
            m2_q    <= '0;
            m3_q    <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stg_q   <= stg_d;
            m0_q    <= m0_d;
            m1_q    <= m1_d;
            m2_q    <= m2_d;
            m3_q    <= m3_d;
        end
    end

`ifdef FFT_LANE_MASK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lane_en_q <= '0;
        else        lane_en_q <= lane_en_d;
    end
`endif

    assign busy      = (state_q == StRun);
    assign done      = (state_q == StDone);
    assign stage_num = stg_q;
    assign counter   = cnt_q;
    assign m0_s      = m0_q;
    assign m1_s      = m1_q;
    assign m2_s      = m2_q;
    assign m3_s      = m3_q;

endmodule

// File: tb/tb_fft_mux_sequencer.sv
// Self-checking bench for fft_mux_sequencer: cycle-index reference model plus
// directed scenarios with literal expectations.
module tb_fft_mux_sequencer;

    localparam int LOG2N = 5;
    localparam int LANES = 4;
    localparam int CNT_W = LOG2N + 1;
    localparam int STG_W = $clog2(LOG2N + 2);
    localparam int PER   = 1 << CNT_W;
    localparam int OUTS  = LOG2N + 1;
    localparam int TOTAL = (LOG2N + 2) * PER;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, stall = 1'b0, abort = 1'b0;
    logic [LANES-1:0] lane_en = '1;
    logic busy, done, m0_s;
    logic [STG_W-1:0] stage_num;
    logic [CNT_W-1:0] counter;
    logic [2*LANES-1:0] m1_s;
    logic [LANES-1:0] m2_s;
    logic [1:0] m3_s;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    fft_mux_sequencer #(.LOG2N(LOG2N), .LANES(LANES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stall     (stall),
        .abort     (abort),
`ifdef FFT_LANE_MASK_EN
        .lane_en   (lane_en),
`endif
        .busy      (busy),
        .done      (done),
        .stage_num (stage_num),
        .counter   (counter),
        .m0_s      (m0_s),
        .m1_s      (m1_s),
        .m2_s      (m2_s),
        .m3_s      (m3_s)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: 0 idle, 1 running (k = cycles elapsed in run), 2 done.
    int m_state = 0;
    int m_k = 0;
    logic [LANES-1:0] m_mask = '1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state <= 0;
            m_k     <= 0;
        end else begin
            case (m_state)
                0: if (start && !abort) begin
                    m_state <= 1;
                    m_k     <= 0;
`ifdef FFT_LANE_MASK_EN
                    m_mask  <= lane_en;
`else
                    m_mask  <= '1;
`endif
                end
                1: if (abort) m_state <= 0;
                   else if (!stall) begin
                       if (m_k == TOTAL - 1) m_state <= 2;
                       else m_k <= m_k + 1;
                   end
                default: m_state <= 0;
            endcase
        end
    end

    logic e_busy, e_done, e_m0;
    logic [31:0] e_stg, e_cnt;
    logic [2*LANES-1:0] e_m1;
    logic [LANES-1:0] e_m2;
    logic [1:0] e_m3;

    always_comb begin
        e_busy = (m_state == 1);
        e_done = (m_state == 2);
        e_stg  = 0;
        e_cnt  = 0;
        e_m0   = 1'b0;
        e_m1   = '0;
        e_m2   = '0;
        e_m3   = 2'b00;
        if (m_state == 1) begin
            e_stg = m_k / PER;
            e_cnt = m_k % PER;
            if (e_stg == 0) e_m0 = 1'b1;
            else if (e_stg == OUTS) e_m3 = 2'b11;
            else begin
                for (int l = 0; l < LANES; l++) begin
                    if (m_mask[l]) begin
                        if (e_cnt >= PER / 2) begin
                            e_m1[2*l +: 2] = 2'b01;
                            e_m2[l] = 1'b1;
                        end else if (e_stg >= 2) begin
                            e_m1[2*l +: 2] = 2'b10;
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 32'(busy), 32'(e_busy));
            check("done", 32'(done), 32'(e_done));
            check("stage_num", 32'(stage_num), e_stg);
            check("counter", 32'(counter), e_cnt);
            check("m0_s", 32'(m0_s), 32'(e_m0));
            check("m1_s", 32'(m1_s), 32'(e_m1));
            check("m2_s", 32'(m2_s), 32'(e_m2));
            check("m3_s", 32'(m3_s), 32'(e_m3));
        end
    end

    // Runs one sequence from a start pulse; start is held into RUN to show it is ignored.
    task automatic run_seq(input int stall_at, input logic [31:0] m1_lo, input logic [31:0] m1_hi,
                           input logic [31:0] m2_hi, output int nbusy, output int done_idx,
                           output int ndone);
        start = 1'b1;
        nbusy = 0;
        done_idx = 0;
        ndone = 0;
        for (int i = 1; i <= 600; i++) begin
            @(negedge clk);
            if (i == 3) start = 1'b0;
`ifdef FFT_LANE_MASK_EN
            if (i == 2) lane_en = '1;
`endif
            if (busy) nbusy++;
            if (done) begin
                ndone++;
                if (done_idx == 0) done_idx = i;
            end
            if (i == 1) check("first_run_cycle", {stage_num, counter}, 0);
            if (stall_at == 0 && i == 224) begin
                check("s3c31_m1", 32'(m1_s), m1_lo);
                check("s3c31_m2", 32'(m2_s), 0);
            end
            if (stall_at == 0 && i == 225) begin
                check("s3c32_m1", 32'(m1_s), m1_hi);
                check("s3c32_m2", 32'(m2_s), m2_hi);
            end
            if (stall_at == 0 && i == 448)
                check("last_run_cycle", {stage_num, counter, m3_s}, {3'd6, 6'd63, 2'b11});
            if (stall_at != 0 && i == stall_at) stall = 1'b1;
            if (stall_at != 0 && i == stall_at + 5) begin
                check("stall_hold", {stage_num, counter}, {3'd2, 6'd10});
                stall = 1'b0;
            end
        end
    endtask

    int nb, di, nd;

    initial begin
        #12;
        check("reset_state", {busy, done, stage_num, counter, m0_s, m1_s, m2_s, m3_s}, 0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        // Plain run.
        run_seq(0, 32'hAA, 32'h55, 32'hF, nb, di, nd);
        check("busy_cycles", nb, 448);
        check("done_index", di, 449);
        check("done_pulses", nd, 1);

        // Five-cycle stall at stage 2, counter 10.
        run_seq(139, 32'hAA, 32'h55, 32'hF, nb, di, nd);
        check("stall_busy_cycles", nb, 453);
        check("stall_done_index", di, 454);

        // Abort at stage 4 together with stall and start.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (259) @(negedge clk);
        check("pre_abort_stage", 32'(stage_num), 4);
        abort = 1'b1;
        stall = 1'b1;
        start = 1'b1;
        @(negedge clk);
        check("abort_outputs", {busy, done, stage_num, counter, m0_s, m1_s, m2_s, m3_s}, 0);
        abort = 1'b0;
        stall = 1'b0;
        start = 1'b0;
        nd = 0;
        nb = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done) nd++;
            if (busy) nb++;
        end
        check("abort_no_done", nd, 0);
        check("abort_idle", nb, 0);

        // Asynchronous reset at stage 5.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (329) @(negedge clk);
        check("pre_reset_stage", 32'(stage_num), 5);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset", {busy, done, stage_num, counter, m0_s, m1_s, m2_s, m3_s}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_seq(0, 32'hAA, 32'h55, 32'hF, nb, di, nd);
        check("post_reset_busy_cycles", nb, 448);
        check("post_reset_done_index", di, 449);

`ifdef FFT_LANE_MASK_EN
        lane_en = 4'b0101;
        run_seq(0, 32'h22, 32'h11, 32'h5, nb, di, nd);
        check("mask_busy_cycles", nb, 448);
        check("mask_done_index", di, 449);
`endif

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
